// File: rtl/inpkt_header_v2.sv
// Version-2 input packet header parser / checksum verifier for the pkt_comm input path.
// Optional error recovery and err_clr handling are enabled by defining INPKT_ERR_RECOVER_EN.
module inpkt_header_v2 #(
  parameter int VERSION           = 2,
  parameter int PKT_MAX_LEN       = 65536,
  parameter int PKT_MAX_TYPE      = 7,
  parameter int CHECKSUM_INTERVAL = 0,
  parameter int DISABLE_CHECKSUM  = 0,
  localparam int TYPE_W           = $clog2(PKT_MAX_TYPE + 1)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [7:0]        din,
  input  logic              wr_en,
  output logic [TYPE_W-1:0] pkt_type,
  output logic [15:0]       pkt_id,
  output logic [23:0]       pkt_len,
  output logic              pkt_data,
  output logic              pkt_end,
  output logic              pkt_err,
  output logic              err_pkt_version,
  output logic              err_pkt_type,
  output logic              err_pkt_len,
  output logic              err_pkt_checksum,
  input  logic              err_clr
);

  typedef enum logic [3:0] {
    ST_VERSION, ST_TYPE, ST_RSV0_0, ST_RSV0_1, ST_LEN0, ST_LEN1, ST_LEN2, ST_RSV1,
    ST_ID0, ST_ID1, ST_HDR_CSUM, ST_DATA, ST_DATA_CSUM, ST_END_CSUM, ST_ERROR
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] sum;
  logic [1:0]  bpos;
  logic [1:0]  cpos;
  logic [23:0] csum_lo;
  logic [23:0] dcnt;
  logic [23:0] icnt;
  logic [15:0] len_lo;
  logic [7:0]  id_lo;

  // Word-wise LE sum equals the sum of each byte shifted to its lane, so no word buffer is needed.
  logic [31:0] byte_term;
  logic [23:0] len_full;
  logic        type_bad, len_bad, csum_bad, csum_last, last_byte, int_hit;
  logic        set_ver, set_type, set_len, set_csum;

  assign byte_term = 32'(din) << {bpos, 3'b000};
  assign len_full  = {din, len_lo};
  assign type_bad  = (din == 8'd0) || (32'(din) > 32'(PKT_MAX_TYPE));
  assign len_bad   = (len_full == 24'd0) || (32'(len_full) > 32'(PKT_MAX_LEN));
  assign csum_bad  = (DISABLE_CHECKSUM == 0) && ({din, csum_lo} != ~sum);
  assign csum_last = (cpos == 2'd3);
  assign last_byte = (dcnt == pkt_len - 24'd1);
  assign int_hit   = (CHECKSUM_INTERVAL != 0) && (icnt == 24'(CHECKSUM_INTERVAL - 1));

  assign set_ver  = wr_en && (state == ST_VERSION) && (din != 8'd0) && (din != 8'(VERSION));
  assign set_type = wr_en && (state == ST_TYPE) && type_bad;
  assign set_len  = wr_en && (state == ST_LEN2) && len_bad;
  assign set_csum = wr_en && csum_last && csum_bad &&
                    ((state == ST_HDR_CSUM) || (state == ST_DATA_CSUM) || (state == ST_END_CSUM));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_VERSION;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (wr_en) begin
      case (state)
        ST_VERSION:   if (din != 8'd0) state_nxt = (din == 8'(VERSION)) ? ST_TYPE : ST_ERROR;
        ST_TYPE:      state_nxt = type_bad ? ST_ERROR : ST_RSV0_0;
        ST_RSV0_0:    state_nxt = ST_RSV0_1;
        ST_RSV0_1:    state_nxt = ST_LEN0;
        ST_LEN0:      state_nxt = ST_LEN1;
        ST_LEN1:      state_nxt = ST_LEN2;
        ST_LEN2:      state_nxt = len_bad ? ST_ERROR : ST_RSV1;
        ST_RSV1:      state_nxt = ST_ID0;
        ST_ID0:       state_nxt = ST_ID1;
        ST_ID1:       state_nxt = ST_HDR_CSUM;
        ST_HDR_CSUM:  if (csum_last) state_nxt = csum_bad ? ST_ERROR : ST_DATA;
        // The end checksum takes precedence when an interval boundary lands on the last byte.
        ST_DATA:      state_nxt = last_byte ? ST_END_CSUM : (int_hit ? ST_DATA_CSUM : ST_DATA);
        ST_DATA_CSUM: if (csum_last) state_nxt = csum_bad ? ST_ERROR : ST_DATA;
        ST_END_CSUM:  if (csum_last) state_nxt = csum_bad ? ST_ERROR : ST_VERSION;
`ifdef INPKT_ERR_RECOVER_EN
        ST_ERROR:     state_nxt = ST_VERSION;
`else
        ST_ERROR:     state_nxt = ST_ERROR;
`endif
        default:      state_nxt = ST_ERROR;
      endcase
    end
  end

  always_comb begin
    pkt_data = 1'b0;
    pkt_end  = 1'b0;
    pkt_err  = 1'b0;
    case (state)
      ST_DATA:  begin pkt_data = 1'b1; pkt_end = last_byte; end
      ST_ERROR: pkt_err = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sum <= '0; bpos <= '0; cpos <= '0; csum_lo <= '0;
      dcnt <= '0; icnt <= '0; len_lo <= '0; id_lo <= '0;
      pkt_type <= '0; pkt_id <= '0; pkt_len <= '0;
    end else if (wr_en) begin
      case (state)
        ST_VERSION: if (din != 8'd0) begin sum <= 32'(din); bpos <= 2'd1; end
        ST_TYPE, ST_RSV0_0, ST_RSV0_1, ST_LEN0, ST_LEN1, ST_LEN2, ST_RSV1, ST_ID0, ST_ID1,
        ST_DATA: begin
          sum  <= sum + byte_term;
          bpos <= bpos + 2'd1;
        end
        ST_HDR_CSUM, ST_DATA_CSUM, ST_END_CSUM: begin
          cpos <= cpos + 2'd1;
          case (cpos)
            2'd0:    csum_lo[7:0]   <= din;
            2'd1:    csum_lo[15:8]  <= din;
            2'd2:    csum_lo[23:16] <= din;
            default: begin sum <= '0; bpos <= '0; end
          endcase
        end
        default: ;
      endcase
      case (state)
        ST_TYPE:     if (!type_bad) pkt_type <= din[TYPE_W-1:0];
        ST_LEN0:     len_lo[7:0]  <= din;
        ST_LEN1:     len_lo[15:8] <= din;
        ST_LEN2:     if (!len_bad) pkt_len <= len_full;
        ST_ID0:      id_lo <= din;
        ST_ID1:      pkt_id <= {din, id_lo};
        ST_HDR_CSUM: begin dcnt <= '0; icnt <= '0; end
        ST_DATA: begin
          dcnt <= dcnt + 24'd1;
          icnt <= int_hit ? 24'd0 : icnt + 24'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_pkt_version  <= 1'b0;
      err_pkt_type     <= 1'b0;
      err_pkt_len      <= 1'b0;
      err_pkt_checksum <= 1'b0;
`ifdef INPKT_ERR_RECOVER_EN
    end else if (err_clr) begin
      err_pkt_version  <= 1'b0;
      err_pkt_type     <= 1'b0;
      err_pkt_len      <= 1'b0;
      err_pkt_checksum <= 1'b0;
`endif
    end else begin
      if (set_ver)  err_pkt_version  <= 1'b1;
      if (set_type) err_pkt_type     <= 1'b1;
      if (set_len)  err_pkt_len      <= 1'b1;
      if (set_csum) err_pkt_checksum <= 1'b1;
    end
  end

`ifndef INPKT_ERR_RECOVER_EN
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
`endif

endmodule

// File: tb/tb_inpkt_header_v2.sv
// Scoreboard bench for inpkt_header_v2: stimulus pushes per-byte expectations, a negedge monitor checks them.
// A second instance with checksum comparison disabled shares the stimulus.
module tb_inpkt_header_v2;

`ifdef INPKT_ERR_RECOVER_EN
  localparam bit REC = 1'b1;
`else
  localparam bit REC = 1'b0;
`endif
  localparam int CI = 8;

  // Scenario-1 packet: type 1, len 3, id 0x1234, data 11 22 33, checksums worked out by hand.
  localparam logic [7:0] TBL [21] = '{
    8'h02, 8'h01, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h34, 8'h12,
    8'hC6, 8'hEC, 8'hFF, 8'hFF, 8'h11, 8'h22, 8'h33, 8'hEE, 8'hDD, 8'hCC, 8'hFF};

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic d, e, err, ev, et, el, ec;
    logic [2:0] typ;
    logic [15:0] id;
    logic [23:0] len;
  } exp_t;

  logic CLK = 1'b0, RST_N = 1'b0, wr_en = 1'b0, err_clr = 1'b0, probe = 1'b0;
  logic [7:0] din = 8'h00;
  logic [2:0] pkt_type, n_type;
  logic [15:0] pkt_id, n_id;
  logic [23:0] pkt_len, n_len;
  logic pkt_data, pkt_end, pkt_err, ev, et, el, ec;
  logic n_data, n_end, n_err, n_ev, n_et, n_el, n_ec;

  logic e_err = 0, e_ev = 0, e_et = 0, e_el = 0, e_ec = 0;
  logic [2:0] e_type = 0;
  logic [15:0] e_id = 0;
  logic [23:0] e_len = 0;

  exp_t q[$];
  exp_t mx;
  int total = 0, bad = 0;

  always #5 CLK = ~CLK;

  inpkt_header_v2 #(.CHECKSUM_INTERVAL(CI)) dut (
    .CLK(CLK), .RST_N(RST_N), .din(din), .wr_en(wr_en), .pkt_type(pkt_type), .pkt_id(pkt_id),
    .pkt_len(pkt_len), .pkt_data(pkt_data), .pkt_end(pkt_end), .pkt_err(pkt_err),
    .err_pkt_version(ev), .err_pkt_type(et), .err_pkt_len(el), .err_pkt_checksum(ec),
    .err_clr(err_clr));

  inpkt_header_v2 #(.CHECKSUM_INTERVAL(CI), .DISABLE_CHECKSUM(1)) u_nock (
    .CLK(CLK), .RST_N(RST_N), .din(din), .wr_en(wr_en), .pkt_type(n_type), .pkt_id(n_id),
    .pkt_len(n_len), .pkt_data(n_data), .pkt_end(n_end), .pkt_err(n_err),
    .err_pkt_version(n_ev), .err_pkt_type(n_et), .err_pkt_len(n_el), .err_pkt_checksum(n_ec),
    .err_clr(err_clr));

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (wr_en || probe) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL scoreboard_empty: got no entry expected one at %0t", $time);
      end else begin
        mx = q.pop_front();
        chk("pkt_data", pkt_data, mx.d);
        chk("pkt_end", pkt_end, mx.e);
        chk("pkt_err", pkt_err, mx.err);
        chk("err_version", ev, mx.ev);
        chk("err_type", et, mx.et);
        chk("err_len", el, mx.el);
        chk("err_checksum", ec, mx.ec);
        chk("pkt_type", pkt_type, mx.typ);
        chk("pkt_id", pkt_id, mx.id);
        chk("pkt_len", pkt_len, mx.len);
        chk("nock_err_checksum", n_ec, 0);
      end
    end
  end

  function automatic logic [31:0] csum(input bq_t b);
    logic [31:0] s = 0, w;
    for (int i = 0; i < b.size(); i += 4) begin
      w = 0;
      for (int j = 0; j < 4; j++) if (i + j < b.size()) w[8*j +: 8] = b[i+j];
      s += w;
    end
    return ~s;
  endfunction

  task automatic push_exp(input logic d, input logic e);
    exp_t x;
    x.d = d; x.e = e; x.err = e_err; x.ev = e_ev; x.et = e_et; x.el = e_el; x.ec = e_ec;
    x.typ = e_type; x.id = e_id; x.len = e_len;
    q.push_back(x);
  endtask

  task automatic send(input logic [7:0] b, input logic d, input logic e);
    @(posedge CLK); #1;
    din = b; wr_en = 1'b1; probe = 1'b0; err_clr = 1'b0;
    push_exp(d, e);
  endtask

  task automatic idle_probe();
    @(posedge CLK); #1;
    wr_en = 1'b0; probe = 1'b1; err_clr = 1'b0;
    push_exp(1'b0, 1'b0);
  endtask

  task automatic clr_pulse();
    @(posedge CLK); #1;
    wr_en = 1'b0; probe = 1'b1; err_clr = 1'b1;
    push_exp(1'b0, 1'b0);
    if (REC) begin e_ev = 0; e_et = 0; e_el = 0; e_ec = 0; end
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    wr_en = 1'b0; err_clr = 1'b0; RST_N = 1'b0;
    e_err = 0; e_ev = 0; e_et = 0; e_el = 0; e_ec = 0; e_type = 0; e_id = 0; e_len = 0;
    probe = 1'b1;
    push_exp(1'b0, 1'b0);
    @(posedge CLK); #1;
    probe = 1'b0; RST_N = 1'b1;
  endtask

  task automatic send_table(input int n, input bit live);
    for (int i = 0; i < n; i++) begin
      send(TBL[i], live && i >= 14 && i <= 16, live && i == 16);
      if (live) begin
        if (i == 1) e_type = 3'd1;
        if (i == 6) e_len = 24'd3;
        if (i == 9) e_id = 16'h1234;
      end
    end
  endtask

  task automatic send_csum(input logic [31:0] c, input bit corrupt);
    logic [7:0] b;
    for (int j = 0; j < 4; j++) begin
      b = c[8*j +: 8];
      if (corrupt && j == 3) b = b + 8'd1;
      send(b, 1'b0, 1'b0);
    end
  endtask

  task automatic send_pkt(input logic [2:0] typ, input logic [23:0] len, input logic [15:0] id,
                          input logic [7:0] seed, input bit bad_last);
    bq_t hb, ch;
    logic [7:0] b;
    hb = '{8'h02, 8'(typ), 8'h00, 8'h00, len[7:0], len[15:8], len[23:16], 8'h00, id[7:0], id[15:8]};
    for (int i = 0; i < 10; i++) begin
      send(hb[i], 1'b0, 1'b0);
      if (i == 1) e_type = typ;
      if (i == 6) e_len = len;
      if (i == 9) e_id = id;
    end
    send_csum(csum(hb), 1'b0);
    ch = {};
    for (int k = 0; k < int'(len); k++) begin
      b = seed + 8'(17 * k);
      send(b, 1'b1, k == int'(len) - 1);
      ch.push_back(b);
      if ((k + 1) % CI == 0 && k + 1 < int'(len)) begin
        send_csum(csum(ch), 1'b0);
        ch = {};
      end
    end
    send_csum(csum(ch), bad_last);
    if (bad_last) begin e_ec = 1; e_err = 1; end
  endtask

  initial begin
    do_reset();
    // Valid packet, then the same packet behind leading zero padding.
    send_table(21, 1'b1);
    idle_probe();
    send(8'h00, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    send_table(21, 1'b1);
    idle_probe();
    // Interval checksums: len 20 has two inserted fields, len 16 ends on a boundary.
    send_pkt(3'd2, 24'd20, 16'hBEEF, 8'h40, 1'b0);
    idle_probe();
    send_pkt(3'd3, 24'd16, 16'h0102, 8'h80, 1'b0);
    idle_probe();
    // Corrupted final checksum byte.
    send_pkt(3'd1, 24'd5, 16'h55AA, 8'h07, 1'b1);
    idle_probe();
    send(8'hAA, 1'b0, 1'b0);
    e_err = !REC;
    idle_probe();
    // Bad version, junk byte, then a valid packet (parsed only with recovery), then err_clr.
    do_reset();
    send(8'h05, 1'b0, 1'b0);
    e_ev = 1; e_err = 1;
    idle_probe();
    send(8'h5A, 1'b0, 1'b0);
    e_err = !REC;
    send_table(21, REC);
    idle_probe();
    clr_pulse();
    idle_probe();
    // Type 0.
    do_reset();
    send(8'h02, 1'b0, 1'b0);
    send(8'h00, 1'b0, 1'b0);
    e_et = 1; e_err = 1;
    idle_probe();
    // Length 0 and length 65537.
    do_reset();
    send(8'h02, 0, 0); send(8'h01, 0, 0); e_type = 3'd1;
    send(8'h00, 0, 0); send(8'h00, 0, 0);
    send(8'h00, 0, 0); send(8'h00, 0, 0); send(8'h00, 0, 0);
    e_el = 1; e_err = 1;
    idle_probe();
    do_reset();
    send(8'h02, 0, 0); send(8'h04, 0, 0); e_type = 3'd4;
    send(8'h00, 0, 0); send(8'h00, 0, 0);
    send(8'h01, 0, 0); send(8'h00, 0, 0); send(8'h01, 0, 0);
    e_el = 1; e_err = 1;
    idle_probe();
    // Reset asserted in the middle of packet data.
    do_reset();
    send_table(16, 1'b1);
    do_reset();
    idle_probe();
    @(posedge CLK); #1;
    wr_en = 1'b0; probe = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge CLK);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/inpkt_header_v2.md
Name: inpkt_header_v2

Overview:
- Version-2 input packet header parser and checksum verifier for the pkt_comm input path.
- Consumes the byte stream from the input FIFO and decodes the 10-byte header.
- Flags data bytes to the downstream packet handler.
- Verifies 32-bit checksums after the header, after every CHECKSUM_INTERVAL data bytes, and after packet end.
- Successor of the v1 parser: adds interval checksums, a length output, an asynchronous reset and optional error recovery.

Parameters:
- VERSION, 2: required value of the header version byte.
- PKT_MAX_LEN, 65536: maximum data length in bytes; must be ≥65536 and ≤2^24.
- PKT_MAX_TYPE, 7: highest legal packet type; type 0 is always illegal.
- CHECKSUM_INTERVAL, 0: data bytes per intermediate checksum. 0 = end-of-packet checksum only. Otherwise a power of 2, ≥4.
- DISABLE_CHECKSUM, 0: 1 = checksum bytes are consumed but never compared.

Ports:
- CLK  in  1  clock
- RST_N  in  1  reset; one clock; reset is asynchronous and active-low
- din  in  8  input byte
- wr_en  in  1  din valid; byte consumed on this edge
- pkt_type  out  MSB(PKT_MAX_TYPE)+1  type of current packet
- pkt_id  out  16  packet id
- pkt_len  out  24  data length as received (not minus 1)
- pkt_data  out  1  current byte (if wr_en) is packet data
- pkt_end  out  1  current byte is last data byte
- pkt_err  out  1  parser in ERROR
- err_pkt_version, err_pkt_type, err_pkt_len, err_pkt_checksum  out  1 each  sticky error flags
- err_clr  in  1  clears error flags (present only with the optional feature; tie 0 otherwise)

Behaviour:
- Reset (RST_N low, async):
  - State = VERSION; all outputs and error flags = 0.
  - Checksum accumulator, byte and interval counters = 0.
- State advances only on edges with wr_en=1. Outputs are registered except pkt_data, pkt_end and pkt_err, which decode the state.
- Header byte order: version, type, rsv0[2], len[3] (LE), rsv1, id[2] (LE). Reserved bytes are ignored but summed.
- States: VERSION, TYPE, RSV0_0, RSV0_1, LEN0, LEN1, LEN2, RSV1, ID0, ID1, HDR_CSUM, DATA, DATA_CSUM, END_CSUM, ERROR.
- VERSION:
  - din=0 is skipped and not summed.
  - din≠VERSION sets err_pkt_version and goes to ERROR.
  - Otherwise go to TYPE and clear the accumulator.
- TYPE: din=0, din>PKT_MAX_TYPE or high bits set sets err_pkt_type and goes to ERROR; otherwise latch pkt_type.
- LEN2: error if length=0 or length>PKT_MAX_LEN; sets err_pkt_len and goes to ERROR.
- Checksum computation:
  - Bytes are packed LE into 32-bit words.
  - A partial final word is zero-padded.
  - Words are summed mod 2^32.
  - Expected value = ~sum, sent LE in 4 bytes.
  - The accumulator restarts after every checksum field.
  - The header sum covers bytes version..id1.
- Comparison happens on the edge accepting the 4th checksum byte, using din together with the 3 latched bytes.
  - On mismatch, err_pkt_checksum=1 and state=ERROR on that same edge. The following byte is never flagged pkt_data.
- HDR_CSUM → DATA.
- DATA:
  - Counts bytes.
  - On the last byte (count=pkt_len-1), pkt_end=1 and the next state is END_CSUM.
  - If CHECKSUM_INTERVAL≠0 and the interval count reaches CHECKSUM_INTERVAL while more data remains, go to DATA_CSUM, then return to DATA.
  - If the interval boundary coincides with the last byte, only END_CSUM follows; no double checksum.
- END_CSUM → VERSION on success.
- ERROR: terminal until reset (see optional feature); din is ignored.
- Simultaneous wr_en and async reset: reset wins.

Optional Feature:
- Macro: INPKT_ERR_RECOVER_EN.
- Defined:
  - ERROR lasts exactly one wr_en-accepted byte (that byte is discarded), then returns to VERSION and resumes hunting. Zero padding is skipped.
  - Error flags stay set until err_clr=1 on an edge. err_clr has priority over a new error on the same edge.
- Undefined:
  - ERROR is held until RST_N.
  - err_clr is ignored.

Test Plan:
- Valid packet: type 1, len 3, id 0x1234, data 11 22 33, correct checksums → pkt_data high for 3 bytes, pkt_end on 0x33, pkt_len=3, pkt_id=0x1234, no errors, back to VERSION.
- Leading zeros: 00 00 then the same valid packet → zeros ignored; identical response to the first scenario.
- Bad version byte 0x05 → err_pkt_version=1 and pkt_err=1 next cycle. Len 0 → err_pkt_len. Type 0 → err_pkt_type.
- CHECKSUM_INTERVAL=8, len 20 → checksums after data bytes 8 and 16 plus end; pkt_data low during the two 4-byte inserted fields. With len 16, exactly 2 checksums total (one interval, one end).
- Corrupt the last checksum byte (+1) → err_pkt_checksum on that edge. With DISABLE_CHECKSUM=1 → no error.
- With INPKT_ERR_RECOVER_EN:
  - Bad header, then one junk byte, then a valid packet → the valid packet is parsed and the error flag remains.
  - err_clr pulse → flags return to 0.
  - Assert RST_N low mid-DATA → all outputs 0 immediately.
